instr_mem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a framed byte stream (e.g. from a

---
 rtl/instr_mem_loader.sv | 152 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: framed byte stream -> little-endian 32-bit word writes; holds core until a good frame.
// Latency: mem_we one cycle after the 4th byte of a word; byte_ready is combinational from state, low in WRITE/IDLE/DONE/ERR.
module instr_mem_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          TW  = $clog2(TIMEOUT + 1);
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR} state_t;

    state_t          state, state_nxt;
    logic [15:0]     n_words;
    logic [31:0]     word;
    logic [1:0]      lane;
    logic [7:0]      acc;
    logic [TW-1:0]   tcnt;

    logic            xfer;
    logic [15:0]     len_full;
    logic            len_big;
    logic            last_word;
    logic            timed_out;

    assign xfer      = byte_valid && byte_ready;
    assign len_full  = {byte_data, n_words[7:0]};
    assign len_big   = {1'b0, len_full} > CAP;
    assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, n_words};
    assign timed_out = !xfer && (tcnt == TW'(TIMEOUT - 1));

    assign mem_addr  = words_loaded[ADDR_W-1:0];
    assign mem_wdata = word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN0;
            LEN0: begin
                if (xfer)           state_nxt = LEN1;
                else if (timed_out) state_nxt = ERR;
            end
            LEN1: begin
                if (xfer) begin
                    if (len_full == 16'd0) state_nxt = CHK;
                    else if (len_big)      state_nxt = ERR;
                    else                   state_nxt = DATA;
                end else if (timed_out) begin
                    state_nxt = ERR;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (lane == 2'd3) state_nxt = WRITE;
                end else if (timed_out) begin
                    state_nxt = ERR;
                end
            end
            WRITE: state_nxt = last_word ? CHK : DATA;
            CHK: begin
                if (xfer)           state_nxt = (byte_data == acc) ? DONE : ERR;
                else if (timed_out) state_nxt = ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_hold  = 1'b1;
        case (state)
            LEN0, LEN1, DATA, CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
            end
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length, word assembly, checksum, timeout counter (frozen during WRITE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_words      <= '0;
            word         <= '0;
            lane         <= '0;
            acc          <= '0;
            tcnt         <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        n_words      <= '0;
                        lane         <= '0;
                        acc          <= '0;
                        tcnt         <= '0;
                        words_loaded <= '0;
                    end
                end
                WRITE: words_loaded <= words_loaded + 1'b1;
                default: begin
                    if (xfer) begin
                        tcnt <= '0;
                        if (state == LEN0) n_words[7:0]  <= byte_data;
                        if (state == LEN1) n_words[15:8] <= byte_data;
                        if (state == DATA) begin
                            word[{lane, 3'b000} +: 8] <= byte_data;
                            acc                       <= acc ^ byte_data;
                            lane                      <= lane + 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed frames plus randomized frames/gaps against a frame-level model.
module tb_instr_mem_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int CAPW    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready, mem_we, core_hold, busy, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   words_loaded;

    int passed = 0;
    int total  = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] exp_a[$], exp_d[$], obs_a[$], obs_d[$];

    instr_mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_a.push_back(32'(mem_addr));
            obs_d.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left on a falling edge; returns one edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        w = 0;
        while (byte_ready !== 1'b1 && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (w >= 64) chk("ready_wait", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_hold"},  32'(core_hold),    32'd1);
        chk({tag, "_done"},  32'(done),         32'd0);
        chk({tag, "_err"},   32'(error),        32'd0);
        chk({tag, "_we"},    32'(mem_we),       32'd0);
        chk({tag, "_rdy"},   32'(byte_ready),   32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic build_rand(input int n, input bit good);
        logic [7:0] x, b;
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x ^= b;
        end
        frame_q.push_back(good ? x : (x ^ 8'h5A));
    endtask

    // Model: the frame determines the expected writes and outcome; then the frame is driven and compared.
    task automatic run_frame(input string tag, input int maxgap, input bit poke_start);
        int n, nw, nbytes;
        logic [7:0] x;
        bit good;
        n  = int'(frame_q[0]) + 256 * int'(frame_q[1]);
        nw = (n > CAPW) ? 0 : n;
        exp_a.delete(); exp_d.delete();
        obs_a.delete(); obs_d.delete();
        x = 8'h00;
        for (int w = 0; w < nw; w++) begin
            exp_a.push_back(32'(w));
            exp_d.push_back({frame_q[2+4*w+3], frame_q[2+4*w+2], frame_q[2+4*w+1], frame_q[2+4*w]});
            for (int k = 0; k < 4; k++) x ^= frame_q[2+4*w+k];
        end
        good   = (n <= CAPW) && (frame_q[2+4*n] == x);
        nbytes = (n > CAPW) ? 2 : 3 + 4 * n;

        pulse_start();
        for (int i = 0; i < nbytes; i++) begin
            send_byte(frame_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
                chk({tag, "_we_latency"}, 32'(mem_we), 32'd1);
            if (poke_start && i == 4) pulse_start();
        end
        chk({tag, "_done"},  32'(done),         32'(good));
        chk({tag, "_error"}, 32'(error),        32'(!good));
        chk({tag, "_hold"},  32'(core_hold),    32'(!good));
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(nw));
        chk({tag, "_nwr"},   32'(obs_a.size()), 32'(exp_a.size()));
        if (obs_a.size() == exp_a.size()) begin
            for (int w = 0; w < exp_a.size(); w++) begin
                if (w < 2 || w == exp_a.size() - 1 || obs_d[w] !== exp_d[w] || obs_a[w] !== exp_a[w]) begin
                    chk({tag, "_addr"}, obs_a[w], exp_a[w]);
                    chk({tag, "_data"}, obs_d[w], exp_d[w]);
                end
            end
        end
    endtask

    initial begin
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
        run_frame("basic", 0, 1'b0);

        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF1};
        run_frame("badchk", 0, 1'b0);

        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame("empty", 0, 1'b0);

        frame_q = '{8'h01, 8'h01};
        run_frame("toolong", 0, 1'b0);

        // Stream stalls after two payload bytes; error must appear exactly TIMEOUT idle cycles later.
        obs_a.delete(); obs_d.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("tmo_before", 32'(error), 32'd0);
        chk("tmo_busy",   32'(busy),  32'd1);
        @(negedge clk);
        chk("tmo_at",     32'(error), 32'd1);
        chk("tmo_hold",   32'(core_hold), 32'd1);
        chk("tmo_nwr",    32'(obs_a.size()), 32'd0);

        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
        run_frame("gaps", 12, 1'b0);

        // Reset in the middle of a word.
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame("afterreset", 0, 1'b1);

        build_rand(CAPW, 1'b1);
        run_frame("full", 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            build_rand(int'($urandom_range(1, 6)), (r != 2));
            run_frame("rand", 12, (r == 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
